pc_ctrl_unit: RTL and testbench
===============================

// Module: pc_ctrl_unit
// PURPOSE
//  Sequencer for the pipeline fetch stage. Arbitrates next-PC source (PC+4, branch, J, JR, IRQ, exception, hold).
//  Detects load-use hazards and issues stall/flush to the IF/ID and ID/EX registers.
//  Latches external interrupts and defers them to a precise point. Sits between decode/execute control and the IF stage.
// PARAMETERS
//  LU_STALL_CYCLES  1  bubbles inserted per load-use hazard (1..7)
//  REG_AW           5  register-index width
// PORTS
//  clk            in   1       pipeline clock
//  reset          in   1       asynchronous, active-low reset
//  IRQ_in         in   1       external interrupt request, level
//  IF_PC31        in   1       supervisor bit of IF_PC; 1 masks IRQ
//  ID_Valid       in   1       ID slot holds a real instruction, not a bubble
//  ID_Jump_I      in   1       J/JAL decoded in ID
//  ID_Jump_R      in   1       JR/JALR decoded in ID
//  ID_EXP         in   1       undefined-instruction exception in ID
//  ID_Rs, ID_Rt   in   REG_AW  ID source registers
//  ID_UsesRt      in   1       ID instruction reads Rt
//  EX_MemRead     in   1       EX instruction is a load
//  EX_Rt          in   REG_AW  load destination in EX
//  EX_Branch_EN   in   1       branch taken, resolved in EX
//  PCSrc          out  3       0 PC+4, 1 branch, 2 JT, 3 JR, 4 ILLOP, 5 XADR, 6 hold
//  IFID_Write     out  1       IF/ID register enable
//  IFID_Flush     out  1       convert IF/ID contents to a bubble
//  IDEX_Flush     out  1       convert ID/EX contents to a bubble
//  ID_IRQ         out  1       one-cycle pulse: IRQ taken; ID writes ID_PC as return address
//  Stalling       out  1       high while in the LU_STALL state
// BEHAVIOUR
//  Reset (async, ~reset): state=RUN, stall_cnt=0, irq_pend=0. Outputs: PCSrc=0, IFID_Write=1, flushes=0, ID_IRQ=0, Stalling=0.
//  irq_pend:
//   - Set on any clk with IRQ_in & ~IF_PC31.
//   - Cleared on the cycle ID_IRQ=1; never cleared otherwise.
//  Load-use (lu) = EX_MemRead & EX_Rt!=0 & (EX_Rt==ID_Rs | (ID_UsesRt & EX_Rt==ID_Rt)).
//  Per-cycle priority, combinational; first match wins:
//   1 EX_Branch_EN -> PCSrc=1, IFID_Flush=1, IDEX_Flush=1. Aborts any stall: state=RUN, cnt=0.
//   2 ID_EXP -> PCSrc=5, IFID_Flush=1, IDEX_Flush=1. irq_pend is retained.
//   3 irq_pend & ~IF_PC31 & ID_Valid & state==RUN & ~lu -> PCSrc=4, ID_IRQ=1, IFID_Flush=1.
//     ID instruction proceeds as the IRQ-entry bubble carrying the return PC.
//   4 lu (state RUN) -> PCSrc=6, IFID_Write=0, IDEX_Flush=1. state=LU_STALL, cnt=LU_STALL_CYCLES-1.
//   5 ID_Jump_R -> PCSrc=3, IFID_Flush=1; else ID_Jump_I -> PCSrc=2, IFID_Flush=1.
//   6 otherwise -> PCSrc=0.
//  FSM, 2 states:
//   - RUN -> LU_STALL on rule 4, but only if LU_STALL_CYCLES>1; with 1 the single cycle completes within RUN.
//   - LU_STALL: PCSrc=6, IFID_Write=0, IDEX_Flush=1, Stalling=1. cnt decrements; cnt==1 -> RUN next cycle.
//   - Rules 1 and 2 override LU_STALL in any cycle.
//  Jumps and the IRQ are never taken while Stalling; they are evaluated once the stall releases.
//  Latency: hazard/branch/jump response is same-cycle combinational; PC register updates at the next edge.
//  Simultaneous events:
//   - Branch+IRQ: branch wins, IRQ deferred.
//   - EXP+IRQ: EXP wins.
//   - Branch+lu: branch wins, no stall.
//  Reset mid-stall: the stall is abandoned immediately; outputs take reset values.
// STRUCTURE
//  cpu_ctrl_pkg: PCSrc localparams (PCS_PC4..PCS_HOLD), FSM state encoding, ILLOP/XADR constants.
//  Sub-module hazard_detect: combinational lu compare, instantiated once.
//  Top level: priority mux, FSM, stall counter, irq_pend flop.
// TESTING
//  1 Reset low mid-LU_STALL (LU_STALL_CYCLES=3) -> Stalling=0, PCSrc=0, IFID_Write=1 asynchronously.
//  2 EX_MemRead=1, EX_Rt=8, ID_Rs=8 -> PCSrc=6, IFID_Write=0, IDEX_Flush=1 for exactly LU_STALL_CYCLES clks.
//    Repeat with EX_Rt=0 -> no stall.
//  3 IRQ_in pulse 1 clk, IF_PC31=0, ID_Valid=0 for 2 clks then 1 -> ID_IRQ pulses on the first ID_Valid clk with PCSrc=4.
//  4 IRQ_in=1 with IF_PC31=1 -> no ID_IRQ ever. Drop IF_PC31 -> ID_IRQ within 2 clks.
//  5 EX_Branch_EN=1, ID_Jump_R=1, irq_pend=1 same clk -> PCSrc=1, both flushes, ID_IRQ=0; ID_IRQ fires later.
//  6 ID_EXP=1 with lu active -> PCSrc=5, IFID_Write=1, no LU_STALL entry.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the fetch-stage sequencer.
//   PCS_* : encodings of the next-PC source select driven on PCSrc.
//           PCS_ILLOP is the interrupt entry, PCS_XADR the exception entry.
//   state_t : two-state sequencer FSM (normal run / load-use stall).
//   CNT_W : width of the load-use bubble counter (covers 1..7 bubbles).
package cpu_ctrl_pkg;

    localparam logic [2:0] PCS_PC4   = 3'd0;
    localparam logic [2:0] PCS_BR    = 3'd1;
    localparam logic [2:0] PCS_JT    = 3'd2;
    localparam logic [2:0] PCS_JR    = 3'd3;
    localparam logic [2:0] PCS_ILLOP = 3'd4;
    localparam logic [2:0] PCS_XADR  = 3'd5;
    localparam logic [2:0] PCS_HOLD  = 3'd6;

    localparam int CNT_W = 3;

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_LU_STALL = 1'b1
    } state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare.
//   ex_mem_read : EX instruction is a load
//   ex_rt       : load destination register in EX
//   id_rs/id_rt : source registers of the instruction in ID
//   id_uses_rt  : ID instruction actually reads Rt
//   lu          : ID needs the load result before it is available
// Register 0 is hard-wired zero, so a load into it never creates a hazard.
module hazard_detect #(
    parameter int REG_AW = 5
) (
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    output logic              lu
);

    assign lu = ex_mem_read && (ex_rt != '0) &&
                ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/pc_ctrl_unit.sv
// Fetch-stage sequencer: picks the next-PC source, inserts load-use
// bubbles, flushes squashed instructions and takes latched interrupts at a
// precise point (a real instruction in ID, no hazard, no stall).
//   clk, reset            : pipeline clock, asynchronous active-low reset
//   IRQ_in, IF_PC31       : level interrupt request, supervisor mask bit
//   ID_Valid, ID_Jump_I, ID_Jump_R, ID_EXP, ID_Rs, ID_Rt, ID_UsesRt : decode info
//   EX_MemRead, EX_Rt, EX_Branch_EN : execute info
//   PCSrc                 : next-PC source select (see cpu_ctrl_pkg)
//   IFID_Write            : IF/ID enable (0 holds the fetched instruction)
//   IFID_Flush/IDEX_Flush : turn the register contents into a bubble
//   ID_IRQ                : one-cycle interrupt-taken pulse
//   Stalling              : FSM is in the load-use stall state
//   dbg_state             : raw FSM state
//
// Handshake/timing: every response is combinational on the current cycle's
// inputs and registered state; the PC register consumes PCSrc at the next
// rising edge. There is no back-pressure beyond IFID_Write.
module pc_ctrl_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int LU_STALL_CYCLES = 1,  // bubbles per load-use hazard, 1..7
    parameter int REG_AW          = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              IRQ_in,
    input  logic              IF_PC31,
    input  logic              ID_Valid,
    input  logic              ID_Jump_I,
    input  logic              ID_Jump_R,
    input  logic              ID_EXP,
    input  logic [REG_AW-1:0] ID_Rs,
    input  logic [REG_AW-1:0] ID_Rt,
    input  logic              ID_UsesRt,
    input  logic              EX_MemRead,
    input  logic [REG_AW-1:0] EX_Rt,
    input  logic              EX_Branch_EN,
    output logic [2:0]        PCSrc,
    output logic              IFID_Write,
    output logic              IFID_Flush,
    output logic              IDEX_Flush,
    output logic              ID_IRQ,
    output logic              Stalling,
    output logic              dbg_state
);

    // The first bubble is issued from RUN, so the stall state covers the rest.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LU_STALL_CYCLES - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             irq_pend, irq_pend_n;
    logic             lu;
    logic             irq_take;

    hazard_detect #(.REG_AW(REG_AW)) u_hazard (
        .ex_mem_read (EX_MemRead),
        .ex_rt       (EX_Rt),
        .id_rs       (ID_Rs),
        .id_rt       (ID_Rt),
        .id_uses_rt  (ID_UsesRt),
        .lu          (lu)
    );

    // Interrupt entry point must be precise: a real instruction in ID that
    // neither waits on a load nor sits behind a stall.
    assign irq_take = irq_pend && !IF_PC31 && ID_Valid && (state == ST_RUN) && !lu;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_RUN;
            cnt      <= '0;
            irq_pend <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            irq_pend <= irq_pend_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (EX_Branch_EN || ID_EXP) begin
            // Redirects squash the stalled instruction; the stall is moot.
            state_n = ST_RUN;
            cnt_n   = '0;
        end else if (state == ST_LU_STALL) begin
            cnt_n = cnt - CNT_W'(1);
            if (cnt <= CNT_W'(1)) begin
                state_n = ST_RUN;
                cnt_n   = '0;
            end
        end else if ((LU_STALL_CYCLES > 1) && !irq_take && lu) begin
            state_n = ST_LU_STALL;
            cnt_n   = CNT_LOAD;
        end
    end

    // A level request still asserted while the interrupt is being taken
    // re-arms the pending flag, so the set term wins over the clear.
    always_comb begin
        irq_pend_n = (irq_pend && !ID_IRQ) || (IRQ_in && !IF_PC31);
    end

    // Output logic: fixed priority, first match wins.
    always_comb begin
        PCSrc      = PCS_PC4;
        IFID_Write = 1'b1;
        IFID_Flush = 1'b0;
        IDEX_Flush = 1'b0;
        ID_IRQ     = 1'b0;
        Stalling   = (state == ST_LU_STALL);
        if (!reset) begin
            // Outputs follow the reset values while reset is held.
            Stalling = 1'b0;
        end else if (EX_Branch_EN) begin
            PCSrc      = PCS_BR;
            IFID_Flush = 1'b1;
            IDEX_Flush = 1'b1;
        end else if (ID_EXP) begin
            PCSrc      = PCS_XADR;
            IFID_Flush = 1'b1;
            IDEX_Flush = 1'b1;
        end else if (state == ST_LU_STALL) begin
            PCSrc      = PCS_HOLD;
            IFID_Write = 1'b0;
            IDEX_Flush = 1'b1;
        end else if (irq_take) begin
            PCSrc      = PCS_ILLOP;
            ID_IRQ     = 1'b1;
            IFID_Flush = 1'b1;
        end else if (lu) begin
            PCSrc      = PCS_HOLD;
            IFID_Write = 1'b0;
            IDEX_Flush = 1'b1;
        end else if (ID_Jump_R) begin
            PCSrc      = PCS_JR;
            IFID_Flush = 1'b1;
        end else if (ID_Jump_I) begin
            PCSrc      = PCS_JT;
            IFID_Flush = 1'b1;
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_pc_ctrl_unit.sv
module tb_pc_ctrl_unit;

    localparam int N_LU   = 3;
    localparam int REG_AW = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              IRQ_in, IF_PC31, ID_Valid, ID_Jump_I, ID_Jump_R, ID_EXP;
    logic [REG_AW-1:0] ID_Rs, ID_Rt, EX_Rt;
    logic              ID_UsesRt, EX_MemRead, EX_Branch_EN;
    logic [2:0]        PCSrc;
    logic              IFID_Write, IFID_Flush, IDEX_Flush, ID_IRQ, Stalling, dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    pc_ctrl_unit #(.LU_STALL_CYCLES(N_LU), .REG_AW(REG_AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .IRQ_in       (IRQ_in),
        .IF_PC31      (IF_PC31),
        .ID_Valid     (ID_Valid),
        .ID_Jump_I    (ID_Jump_I),
        .ID_Jump_R    (ID_Jump_R),
        .ID_EXP       (ID_EXP),
        .ID_Rs        (ID_Rs),
        .ID_Rt        (ID_Rt),
        .ID_UsesRt    (ID_UsesRt),
        .EX_MemRead   (EX_MemRead),
        .EX_Rt        (EX_Rt),
        .EX_Branch_EN (EX_Branch_EN),
        .PCSrc        (PCSrc),
        .IFID_Write   (IFID_Write),
        .IFID_Flush   (IFID_Flush),
        .IDEX_Flush   (IDEX_Flush),
        .ID_IRQ       (ID_IRQ),
        .Stalling     (Stalling),
        .dbg_state    (dbg_state)
    );

    // ---------------- reference model + scoreboard ----------------
    // Model state: bubbles still owed by the stall state, and the pending IRQ.
    int         m_stall = 0;
    bit         m_pend  = 0;
    int         stall_next;
    bit         lu_m;
    logic [2:0] e_pcs;
    bit         e_wr, e_ff, e_xf, e_irq, e_st;
    logic [8:0] exp_q[$];
    logic [8:0] e_vec, a_vec;

    always @(negedge clk) begin
        if (!reset) begin
            m_stall = 0;
            m_pend  = 0;
            exp_q.push_back({3'd0, 1'b1, 5'b00000});
        end else begin
            lu_m  = EX_MemRead && (EX_Rt != 0) &&
                    ((EX_Rt == ID_Rs) || (ID_UsesRt && (EX_Rt == ID_Rt)));
            e_pcs = 3'd0; e_wr = 1; e_ff = 0; e_xf = 0; e_irq = 0;
            e_st  = (m_stall > 0);
            stall_next = (m_stall > 0) ? m_stall - 1 : 0;
            if (EX_Branch_EN) begin
                e_pcs = 3'd1; e_ff = 1; e_xf = 1; stall_next = 0;
            end else if (ID_EXP) begin
                e_pcs = 3'd5; e_ff = 1; e_xf = 1; stall_next = 0;
            end else if (m_stall > 0) begin
                e_pcs = 3'd6; e_wr = 0; e_xf = 1;
            end else if (m_pend && !IF_PC31 && ID_Valid && !lu_m) begin
                e_pcs = 3'd4; e_irq = 1; e_ff = 1;
            end else if (lu_m) begin
                e_pcs = 3'd6; e_wr = 0; e_xf = 1; stall_next = N_LU - 1;
            end else if (ID_Jump_R) begin
                e_pcs = 3'd3; e_ff = 1;
            end else if (ID_Jump_I) begin
                e_pcs = 3'd2; e_ff = 1;
            end
            exp_q.push_back({e_pcs, e_wr, e_ff, e_xf, e_irq, e_st, e_st});
            m_pend  = (m_pend && !e_irq) || (IRQ_in && !IF_PC31);
            m_stall = stall_next;
        end
        a_vec = {PCSrc, IFID_Write, IFID_Flush, IDEX_Flush, ID_IRQ, Stalling, dbg_state};
        e_vec = exp_q.pop_front();
        n_tests++;
        if (a_vec !== e_vec) begin
            n_fail++;
            $display("FAIL model_cycle t=%0t: got pcs=%0d wr/ff/xf/irq/st/ds=%b required pcs=%0d wr/ff/xf/irq/st/ds=%b",
                     $time, a_vec[8:6], a_vec[5:0], e_vec[8:6], e_vec[5:0]);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic idle();
        IRQ_in = 0; IF_PC31 = 0; ID_Valid = 0; ID_Jump_I = 0; ID_Jump_R = 0;
        ID_EXP = 0; ID_Rs = 0; ID_Rt = 0; ID_UsesRt = 0; EX_MemRead = 0;
        EX_Rt = 0; EX_Branch_EN = 0;
    endtask

    task automatic set_lu(input logic [REG_AW-1:0] r);
        EX_MemRead = 1; EX_Rt = r; ID_Rs = r;
    endtask

    task automatic chk(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    // ---------------- directed + random stimulus ----------------
    bit seen;

    initial begin
        reset = 0;
        idle();
        at_neg();
        chk("reset_pcsrc", PCSrc, 0);
        chk("reset_ifid_write", IFID_Write, 1);
        chk("reset_stalling", Stalling, 0);
        chk("reset_id_irq", ID_IRQ, 0);
        tick();
        reset = 1;

        // Load-use hazard: exactly N_LU hold cycles, Stalling on the trailing ones
        tick();
        set_lu(5'd8);
        at_neg();
        chk("lu_first_pcsrc", PCSrc, 6);
        chk("lu_first_write", IFID_Write, 0);
        chk("lu_first_idex_flush", IDEX_Flush, 1);
        chk("lu_first_stalling", Stalling, 0);
        tick();
        idle();
        for (int k = 1; k < N_LU; k++) begin
            at_neg();
            chk("lu_hold_pcsrc", PCSrc, 6);
            chk("lu_hold_stalling", Stalling, 1);
            tick();
        end
        at_neg();
        chk("lu_release_pcsrc", PCSrc, 0);
        chk("lu_release_write", IFID_Write, 1);

        // Load into r0 never stalls
        tick();
        set_lu(5'd0);
        at_neg();
        chk("lu_r0_pcsrc", PCSrc, 0);
        chk("lu_r0_write", IFID_Write, 1);
        tick();
        idle();

        // Rt compare only when the instruction reads Rt
        EX_MemRead = 1; EX_Rt = 5'd5; ID_Rs = 5'd1; ID_Rt = 5'd5; ID_UsesRt = 0;
        at_neg();
        chk("lu_rt_unused", PCSrc, 0);
        tick();
        ID_UsesRt = 1;
        at_neg();
        chk("lu_rt_used", PCSrc, 6);
        tick();
        idle();
        for (int k = 1; k < N_LU; k++) tick();

        // Asynchronous reset in the middle of a stall
        set_lu(5'd8);
        tick();
        idle();
        #1;
        chk("mid_stall_stalling", Stalling, 1);
        #1 reset = 0;
        #1;
        chk("async_rst_stalling", Stalling, 0);
        chk("async_rst_pcsrc", PCSrc, 0);
        chk("async_rst_write", IFID_Write, 1);
        chk("async_rst_idex_flush", IDEX_Flush, 0);
        tick();
        reset = 1;

        // Jumps
        tick();
        ID_Jump_I = 1;
        at_neg();
        chk("jump_i_pcsrc", PCSrc, 2);
        chk("jump_i_flush", IFID_Flush, 1);
        tick();
        ID_Jump_R = 1;
        at_neg();
        chk("jump_r_over_i", PCSrc, 3);
        tick();
        idle();

        // IRQ pulse, deferred until ID holds a real instruction
        IRQ_in = 1;
        at_neg();
        chk("irq_c0", ID_IRQ, 0);
        tick();
        IRQ_in = 0;
        at_neg();
        chk("irq_c1_bubble", ID_IRQ, 0);
        tick();
        ID_Valid = 1;
        at_neg();
        chk("irq_taken", ID_IRQ, 1);
        chk("irq_pcsrc", PCSrc, 4);
        chk("irq_flush", IFID_Flush, 1);
        tick();
        at_neg();
        chk("irq_cleared", ID_IRQ, 0);
        tick();

        // Masked IRQ, then unmask
        IRQ_in = 1; IF_PC31 = 1; ID_Valid = 1;
        for (int k = 0; k < 4; k++) begin
            at_neg();
            chk("irq_masked", ID_IRQ, 0);
            tick();
        end
        IF_PC31 = 0;
        seen = 0;
        for (int k = 0; k < 2; k++) begin
            at_neg();
            if (ID_IRQ) seen = 1;
            if (seen) break;
            tick();
        end
        chk("irq_unmask_2clk", seen, 1);
        // IRQ_in was still high on the taking cycle, so it is pending again
        tick();
        IRQ_in = 0; IF_PC31 = 1;
        at_neg();
        chk("irq_repend_masked", ID_IRQ, 0);

        // Branch + JR + pending IRQ in one cycle
        tick();
        IF_PC31 = 0; EX_Branch_EN = 1; ID_Jump_R = 1;
        at_neg();
        chk("br_win_pcsrc", PCSrc, 1);
        chk("br_win_ifid_flush", IFID_Flush, 1);
        chk("br_win_idex_flush", IDEX_Flush, 1);
        chk("br_win_id_irq", ID_IRQ, 0);
        tick();
        EX_Branch_EN = 0; ID_Jump_R = 0;
        at_neg();
        chk("irq_after_br", ID_IRQ, 1);
        chk("irq_after_br_pcsrc", PCSrc, 4);
        tick();
        idle();

        // Exception beats load-use; no stall entry
        set_lu(5'd3);
        ID_EXP = 1;
        at_neg();
        chk("exp_pcsrc", PCSrc, 5);
        chk("exp_write", IFID_Write, 1);
        chk("exp_idex_flush", IDEX_Flush, 1);
        tick();
        idle();
        at_neg();
        chk("exp_no_stall", Stalling, 0);
        chk("exp_no_stall_pcsrc", PCSrc, 0);

        // Branch aborts a stall in progress
        tick();
        set_lu(5'd9);
        tick();
        idle();
        EX_Branch_EN = 1;
        at_neg();
        chk("br_abort_pcsrc", PCSrc, 1);
        tick();
        idle();
        at_neg();
        chk("br_abort_stalling", Stalling, 0);
        chk("br_abort_pcsrc_next", PCSrc, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            tick();
            reset        = ($urandom_range(0, 99) != 0);
            IRQ_in       = ($urandom_range(0, 9) == 0);
            IF_PC31      = ($urandom_range(0, 1) == 0);
            ID_Valid     = ($urandom_range(0, 9) < 7);
            ID_Jump_I    = ($urandom_range(0, 9) < 2);
            ID_Jump_R    = ($urandom_range(0, 9) == 0);
            ID_EXP       = ($urandom_range(0, 19) == 0);
            ID_Rs        = REG_AW'($urandom_range(0, 3));
            ID_Rt        = REG_AW'($urandom_range(0, 3));
            ID_UsesRt    = ($urandom_range(0, 1) == 0);
            EX_MemRead   = ($urandom_range(0, 9) < 3);
            EX_Rt        = REG_AW'($urandom_range(0, 3));
            EX_Branch_EN = ($urandom_range(0, 9) == 0);
        end
        tick();
        reset = 1;
        idle();
        tick();
        at_neg();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
